noc_out_framer: RTL and testbench
=================================

NOC_OUT_FRAMER -- requirements
Module: noc_out_framer

Interface
REQ-001: Parameter XY_SZ, default 4, tile coordinate width; a tile ID is 2*XY_SZ bits.
REQ-002: Parameter DEPTH, default 16, payload buffer depth in 32-bit words (power of two, 2..128).
REQ-003: clk_line  input  1  sole clock; all logic on rising edge.
REQ-004: clk_line_rst_high  input  1  asynchronous active-high reset.
REQ-005: HsrcId  input  2*XY_SZ  own tile ID, static after reset.
REQ-006: HdstId  input  2*XY_SZ  destination tile ID, sampled with first payload word.
REQ-007: stream_in_TVALID/TDATA[31:0]/TKEEP[3:0]/TLAST  input  payload stream from tile logic.
REQ-008: stream_in_TREADY  output  1  payload accept.
REQ-009: stream_out_TVALID/TDATA[31:0]/TKEEP[3:0]/TLAST  output  framed NoC stream.
REQ-010: stream_out_TREADY  input  1  NoC accept.
REQ-011: pkt_trunc  output  1  one-cycle pulse when a packet is force-closed at DEPTH words.

Function
REQ-012: Transfer occurs on a cycle with TVALID and TREADY both high; no other cycle moves data.
REQ-013: FSM states are IDLE, FILL, HDR and DRAIN (store-and-forward, one packet in flight).
REQ-014: IDLE: stream_in_TREADY=1; an accepted word is written to buffer slot 0, HdstId is latched, count=1, and the FSM enters FILL (or HDR if TLAST=1).
REQ-015: FILL: stream_in_TREADY=1; each accepted word is written at slot count and count increments.
REQ-016: FILL exits to HDR on the cycle an accepted word has TLAST=1 or brings count to DEPTH.
REQ-017: Closure at count==DEPTH without TLAST shall pulse pkt_trunc for 1 cycle; the next input word starts a new packet.
REQ-018: In HDR and DRAIN, stream_in_TREADY=0.
REQ-019: HDR: stream_out_TVALID=1, TDATA = {dst[7:0], src[7:0], len[7:0], 8'hA5} (IDs zero-extended/truncated to 8 bits), TKEEP=4'hF, TLAST=0; len = stored payload word count.
REQ-020: Header is presented the cycle after the final payload word is accepted (1-cycle latency).
REQ-021: HDR advances to DRAIN on header transfer; DRAIN presents stored words in order with stored TKEEP, with rd pointer from 0.
REQ-022: stream_out_TLAST=1 exactly on the word at index len-1 (also when truncated).
REQ-023: Output word/TVALID shall remain stable while TVALID=1 and TREADY=0.
REQ-024: DRAIN returns to IDLE on transfer of the TLAST word; stream_in_TREADY is high the next cycle.
REQ-025: The len field for a DEPTH-word packet shall equal DEPTH (mod 256).
REQ-026: stream_out_TVALID shall be 0 in IDLE and FILL.

Reset
REQ-027: While clk_line_rst_high=1: FSM=IDLE, count and rd pointer=0, all stream_out_* outputs=0, pkt_trunc=0, stream_in_TREADY=0.
REQ-028: stream_in_TREADY rises on the first clock edge after reset deassertion.
REQ-029: Reset asserted mid-packet discards buffered data; no partial packet is emitted afterwards.
REQ-030: Buffer storage is not reset.

Structure
REQ-031: A shared package holds the header marker constant (8'hA5), the header field bit positions, and the FSM state enum.
REQ-032: Payload storage is one sub-module, framer_buf: a DEPTH x 36-bit simple dual-port RAM with one write port and one read port, storing {TKEEP, TDATA}, with a registered or bypassed read chosen so REQ-020 holds.

Verification
REQ-033: HsrcId=8'h12, HdstId=8'h34, 3 words 0x1,0x2,0x3 with TLAST on the third -> header 0x3412_03A5, then 0x1, 0x2, 0x3 with TLAST on 0x3 only.
REQ-034: Single-word packet 0xDEADBEEF with TKEEP=4'h3 and TLAST -> header len=1, payload TKEEP=4'h3, TLAST=1; input not ready for exactly 2 transfer cycles.
REQ-035: DEPTH=16 and 20 words without TLAST -> pkt_trunc pulses once, first packet len=16 with TLAST on word 15, then second packet len=4 carrying words 16..19.
REQ-036: Randomized stream_out_TREADY (50% duty) over 10 packets -> output matches the reference model with no duplicates or drops, and data stays stable under stall.
REQ-037: Reset asserted after 2 of 5 words -> outputs zero immediately, no header emitted, and a subsequent 2-word packet frames correctly with len=2.
REQ-038: HdstId changed mid-FILL from 8'h34 to 8'h56 -> header carries 8'h34.

Source files
------------

// File: rtl/noc_out_framer_pkg.sv
// Shared definitions for the NoC output framer: header layout, marker and FSM states.
package noc_out_framer_pkg;

   localparam logic [7:0] HDR_MARKER  = 8'hA5;
   localparam int unsigned HDR_DST_LSB = 24;
   localparam int unsigned HDR_SRC_LSB = 16;
   localparam int unsigned HDR_LEN_LSB = 8;
   localparam int unsigned HDR_MRK_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_HDR,
      ST_DRAIN
   } state_e;

   function automatic logic [31:0] build_hdr(input logic [7:0] dst,
                                             input logic [7:0] src,
                                             input logic [7:0] len);
      logic [31:0] h;
      h = '0;
      h[HDR_DST_LSB +: 8] = dst;
      h[HDR_SRC_LSB +: 8] = src;
      h[HDR_LEN_LSB +: 8] = len;
      h[HDR_MRK_LSB +: 8] = HDR_MARKER;
      return h;
   endfunction

endpackage

// File: rtl/noc_out_framer_buf.sv
// Payload store: simple dual-port RAM, synchronous write, combinational read so the
// drained word is valid in the same cycle the read pointer selects it.
module framer_buf #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 36,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/noc_out_framer.sv
// Store-and-forward framer: buffers one payload packet, then emits a header word
// followed by the stored payload on the NoC stream.
module noc_out_framer
   import noc_out_framer_pkg::*;
#(
   parameter int unsigned XY_SZ = 4,
   parameter int unsigned DEPTH = 16
) (
   input  logic               clk_line,
   input  logic               clk_line_rst_high,
   input  logic [2*XY_SZ-1:0] HsrcId,
   input  logic [2*XY_SZ-1:0] HdstId,
   input  logic               stream_in_TVALID,
   input  logic [31:0]        stream_in_TDATA,
   input  logic [3:0]         stream_in_TKEEP,
   input  logic               stream_in_TLAST,
   output logic               stream_in_TREADY,
   output logic               stream_out_TVALID,
   output logic [31:0]        stream_out_TDATA,
   output logic [3:0]         stream_out_TKEEP,
   output logic               stream_out_TLAST,
   input  logic               stream_out_TREADY,
   output logic               pkt_trunc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   state_e               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [AW-1:0]        rd_q, rd_d;
   logic [2*XY_SZ-1:0]   dst_q, dst_d;
   logic                 trunc_q, trunc_d;
   logic                 rdy_q;

   logic                 in_acc, out_acc;
   logic [CW-1:0]        count_inc;
   logic                 hit_full, last_rd;
   logic [35:0]          rd_word;

   assign in_acc    = stream_in_TVALID & stream_in_TREADY;
   assign out_acc   = stream_out_TVALID & stream_out_TREADY;
   assign count_inc = count_q + CW'(1);
   assign hit_full  = (count_inc == CW'(DEPTH));
   assign last_rd   = (CW'(rd_q) == count_q - CW'(1));

   framer_buf #(
      .DEPTH (DEPTH),
      .WIDTH (36)
   ) u_buf (
      .clk     (clk_line),
      .we_i    (in_acc),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i ({stream_in_TKEEP, stream_in_TDATA}),
      .raddr_i (rd_q),
      .rdata_o (rd_word)
   );

   always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
      if (clk_line_rst_high) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_acc) state_d = stream_in_TLAST ? ST_HDR : ST_FILL;
         ST_FILL:  if (in_acc && (stream_in_TLAST || hit_full)) state_d = ST_HDR;
         ST_HDR:   if (out_acc) state_d = ST_DRAIN;
         ST_DRAIN: if (out_acc && last_rd) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state; count doubles as write slot and as stored packet length.
   always_comb begin
      count_d = count_q;
      rd_d    = '0;
      dst_d   = dst_q;
      trunc_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_acc) begin
               count_d = CW'(1);
               dst_d   = HdstId;
            end
         end
         ST_FILL: begin
            if (in_acc) begin
               count_d = count_inc;
               trunc_d = hit_full & ~stream_in_TLAST;
            end
         end
         ST_DRAIN: begin
            rd_d = rd_q;
            if (out_acc) begin
               rd_d = rd_q + AW'(1);
               if (last_rd) count_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
      if (clk_line_rst_high) begin
         count_q <= '0;
         rd_q    <= '0;
         dst_q   <= '0;
         trunc_q <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         rd_q    <= rd_d;
         dst_q   <= dst_d;
         trunc_q <= trunc_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      stream_in_TREADY  = 1'b0;
      stream_out_TVALID = 1'b0;
      stream_out_TDATA  = '0;
      stream_out_TKEEP  = '0;
      stream_out_TLAST  = 1'b0;
      pkt_trunc         = trunc_q;
      case (state_q)
         ST_IDLE, ST_FILL: stream_in_TREADY = rdy_q;
         ST_HDR: begin
            stream_out_TVALID = 1'b1;
            stream_out_TDATA  = build_hdr(8'(dst_q), 8'(HsrcId), 8'(count_q));
            stream_out_TKEEP  = 4'hF;
         end
         ST_DRAIN: begin
            stream_out_TVALID = 1'b1;
            stream_out_TDATA  = rd_word[31:0];
            stream_out_TKEEP  = rd_word[35:32];
            stream_out_TLAST  = last_rd;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_noc_out_framer.sv
// Randomized self-checking bench for noc_out_framer against a packet-level queue model.
module tb_noc_out_framer;

   localparam int unsigned XY_SZ = 4;
   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  src_id = 8'h12;
   logic [7:0]  dst_id = 8'h34;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_keep = '0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_last;
   logic        out_ready = 1'b1;
   logic        trunc;

   int checks = 0;
   int failures = 0;

   logic [36:0] exp_q[$];
   logic [35:0] cur_q[$];
   logic [7:0]  cur_dst;
   int          exp_trunc = 0;
   int          trunc_seen = 0;
   bit          rand_en = 1'b0;
   bit          stall_prev = 1'b0;
   logic [36:0] prev_word;

   always #5 clk = ~clk;

   noc_out_framer #(.XY_SZ(XY_SZ), .DEPTH(DEPTH)) dut (
      .clk_line          (clk),
      .clk_line_rst_high (rst),
      .HsrcId            (src_id),
      .HdstId            (dst_id),
      .stream_in_TVALID  (in_valid),
      .stream_in_TDATA   (in_data),
      .stream_in_TKEEP   (in_keep),
      .stream_in_TLAST   (in_last),
      .stream_in_TREADY  (in_ready),
      .stream_out_TVALID (out_valid),
      .stream_out_TDATA  (out_data),
      .stream_out_TKEEP  (out_keep),
      .stream_out_TLAST  (out_last),
      .stream_out_TREADY (out_ready),
      .pkt_trunc         (trunc)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: a packet closes on TLAST or once DEPTH words are held.
   task automatic model_accept(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      if (cur_q.size() == 0) cur_dst = dst_id;
      cur_q.push_back({k, d});
      if (l || cur_q.size() == DEPTH) begin
         if (!l) exp_trunc++;
         n = cur_q.size();
         exp_q.push_back({1'b0, 4'hF, cur_dst, src_id, 8'(n), 8'hA5});
         for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), cur_q[i]});
         cur_q.delete();
      end
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_word", 64'({out_last, out_keep, out_data}), 64'(prev_word));
         end
         if (trunc) trunc_seen++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 64'({out_last, out_keep, out_data}), 64'h0_dead_dead_dead);
            end else begin
               chk("out_word", 64'({out_last, out_keep, out_data}), 64'(exp_q.pop_front()));
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_word  = {out_last, out_keep, out_data};
      end
   end

   task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(d, k, l);
            @(posedge clk);
            #1;
            break;
         end
         n++;
         if (n > 500) begin
            chk("in_timeout", 64'd0, 64'd1);
            break;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int lowcnt;
      int len;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_bus", 64'({out_last, out_keep, out_data}), 64'd0);
      chk("rst_trunc", 64'(trunc), 64'd0);
      rst = 1'b0;
      #1;
      chk("ready_before_edge", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("ready_after_edge", 64'(in_ready), 64'd1);

      // Three-word basic packet
      push_word(32'h1, 4'hF, 1'b0);
      push_word(32'h2, 4'hF, 1'b0);
      push_word(32'h3, 4'hF, 1'b1);
      chk("hdr_latency_valid", 64'(out_valid), 64'd1);
      chk("hdr_value", 64'(out_data), 64'h3412_03A5);
      wait_drain();

      // Single word with partial keep; input must be blocked for exactly two cycles
      push_word(32'hDEADBEEF, 4'h3, 1'b1);
      lowcnt = 0;
      while (!in_ready && lowcnt < 20) begin
         lowcnt++;
         @(posedge clk);
         #1;
      end
      chk("single_ready_low", 64'(lowcnt), 64'd2);
      wait_drain();

      // Twenty words, truncation at DEPTH
      for (int i = 0; i < 20; i++) push_word(32'(i), 4'hF, (i == 19));
      wait_drain();
      chk("trunc_count_a", 64'(trunc_seen), 64'd1);

      // Destination changed after the first word
      dst_id = 8'h34;
      push_word(32'hA0, 4'hF, 1'b0);
      dst_id = 8'h56;
      push_word(32'hA1, 4'hF, 1'b0);
      push_word(32'hA2, 4'hF, 1'b1);
      chk("dst_latched", 64'(out_data[31:24]), 64'h34);
      wait_drain();

      // Reset after two of five words
      dst_id = 8'h34;
      push_word(32'hB0, 4'hF, 1'b0);
      push_word(32'hB1, 4'hF, 1'b0);
      rst = 1'b1;
      #1;
      cur_q.delete();
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_out", 64'({out_valid, out_last, out_keep, out_data}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_no_output", 64'(exp_q.size()), 64'd0);
      push_word(32'hC0, 4'h1, 1'b0);
      push_word(32'hC1, 4'h7, 1'b1);
      chk("post_rst_len", 64'(out_data[15:8]), 64'd2);
      wait_drain();

      // Random packets with output back-pressure and input bubbles
      rand_en = 1'b1;
      for (int p = 0; p < 10; p++) begin
         dst_id = 8'($urandom);
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
            push_word($urandom, 4'($urandom), (i == len - 1));
         end
      end
      wait_drain();
      rand_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      chk("trunc_total", 64'(trunc_seen), 64'(exp_trunc));
      chk("final_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      chk("global_timeout", 64'd0, 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
